// File: rtl/ex_shifter_pipe.sv
// ex_shifter_pipe: pipelined barrel shifter (sll/srl/sra/rol/ror and RV64 *W ops) with valid/ready and flush
module ex_shifter_pipe #(
  parameter int XLEN = 64,
  parameter int STAGES = 2,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic               in_amt_src,
  input  logic [XLEN-1:0]    in_rs1,
  input  logic [XLEN-1:0]    in_rs2,
  input  logic [SHAMT_W-1:0] in_imm,
  input  logic [4:0]         in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_data,
  output logic [4:0]         out_tag,
  output logic               busy
);
  localparam int LPS = (SHAMT_W + STAGES - 1) / STAGES;

  if (!(XLEN == 32 || XLEN == 64) || STAGES < 1 || STAGES > 3) begin : g_bad_params
    $error("ex_shifter_pipe: XLEN must be 32/64 and STAGES 1..3");
  end

  typedef struct packed {
    logic [XLEN-1:0]    d;
    logic [SHAMT_W-1:0] a;
    logic               f;
    logic               r;
    logic               l;
    logic               w;
    logic [4:0]         t;
  } stage_t;

  function automatic logic [XLEN-1:0] rev(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] y;
    for (int i = 0; i < XLEN; i++) y[i] = x[XLEN-1-i];
    return y;
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    return XLEN'({{XLEN{x[31]}}, x});
  endfunction

  // Right shift/rotate through the barrel levels owned by stage st; left ops arrive bit-reversed.
  function automatic logic [XLEN-1:0] levels(input logic [XLEN-1:0] x, input logic [SHAMT_W-1:0] amt,
                                             input logic fb, input logic rot, input int st);
    logic [XLEN-1:0] y;
    y = x;
    for (int i = 0; i < SHAMT_W; i++)
      if (i / LPS == st && amt[i])
        y = rot ? ((y >> (1 << i)) | (y << (XLEN - (1 << i))))
                : ((y >> (1 << i)) | ({XLEN{fb}} & ~({XLEN{1'b1}} >> (1 << i))));
    return y;
  endfunction

  logic [SHAMT_W-1:0] amt;
  logic               word, left, rotate, fill, unused;
  logic [XLEN-1:0]    src, post;
  logic [STAGES-1:0]  v, uv;
  logic [STAGES:0]    adv;
  stage_t             s [STAGES];
  stage_t             u [STAGES];
  stage_t             n [STAGES];

  assign amt    = in_amt_src ? in_imm : in_rs2[SHAMT_W-1:0];
  assign word   = XLEN == 64 && in_op[2] && in_op != 3'b111;
  assign left   = in_op == 3'b000 || in_op == 3'b011 || in_op == 3'b100;
  assign rotate = in_op[1:0] == 2'b11;
  assign fill   = in_op == 3'b010 ? in_rs1[XLEN-1] : in_op == 3'b110 && in_rs1[31];
  assign src    = !word ? in_rs1 : in_op == 3'b110 ? sext32(in_rs1[31:0]) : XLEN'(in_rs1[31:0]);
  assign unused = ^in_rs2;

  // Stage k may load when empty or when its successor drains; the tail drains on out_ready.
  always_comb begin
    adv[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) adv[i] = ~v[i] | adv[i+1];
  end

  assign in_ready = ~rst & ~flush & adv[0];

  // Per-stage next values: each stage applies its share of barrel levels; the tail un-reverses and sign-extends.
  always_comb begin
    u[0]  = '{d: left ? rev(src) : src, a: word ? (amt & SHAMT_W'(31)) : amt,
              f: fill, r: rotate, l: left, w: word, t: in_tag};
    uv    = '0;
    uv[0] = in_valid & in_ready;
    for (int i = 1; i < STAGES; i++) begin
      u[i]  = s[i-1];
      uv[i] = v[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      n[i]   = u[i];
      n[i].d = levels(u[i].d, u[i].a, u[i].f, u[i].r, i);
    end
    post            = n[STAGES-1].l ? rev(n[STAGES-1].d) : n[STAGES-1].d;
    n[STAGES-1].d   = n[STAGES-1].w ? sext32(post[31:0]) : post;
  end

  // Pipeline registers: flush clears valids only, payload loads only with a valid op.
  always_ff @(posedge clk)
    if (rst) begin
      v <= '0;
      s <= '{default: '0};
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        v[i] <= ~flush & (adv[i] ? uv[i] : v[i]);
        if (adv[i] && uv[i]) s[i] <= n[i];
      end
    end

  assign out_valid = v[STAGES-1];
  assign out_data  = s[STAGES-1].d;
  assign out_tag   = s[STAGES-1].t;
  assign busy      = |v;
endmodule

// File: tb/tb_ex_shifter_pipe.sv
// tb_ex_shifter_pipe: directed and scoreboarded checks of ex_shifter_pipe at XLEN=64, STAGES=2
module tb_ex_shifter_pipe;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_amt_src, out_valid, out_ready, busy;
  logic [2:0]  in_op;
  logic [63:0] in_rs1, in_rs2, out_data;
  logic [5:0]  in_imm;
  logic [4:0]  in_tag, out_tag;
  int          checks = 0;
  int          errors = 0;

  ex_shifter_pipe #(.XLEN(64), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_amt_src(in_amt_src), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic src, input logic [63:0] rs1, input logic [63:0] rs2,
                       input logic [5:0] imm, input logic [4:0] tag);
    in_op = op; in_amt_src = src; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_tag = tag;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic src, input logic [63:0] rs1,
                        input logic [63:0] rs2, input logic [5:0] imm, input logic [4:0] tag, input logic [63:0] exp);
    drive(op, src, rs1, rs2, imm, tag);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1 chk({name, "_rdy"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk({name, "_early"}, 64'(out_valid), 64'd0);
    tick();
    chk({name, "_vld"}, 64'(out_valid), 64'd1);
    chk(name, out_data, exp);
    chk({name, "_tag"}, 64'(out_tag), 64'(tag));
    tick();
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] x, input logic [5:0] a);
    logic [31:0] w;
    logic [4:0]  a5;
    a5 = a[4:0];
    case (op)
      3'd0: return x << a;
      3'd1: return x >> a;
      3'd2: return $signed(x) >>> a;
      3'd3: return (x << a) | (x >> (7'd64 - {1'b0, a}));
      3'd4: w = x[31:0] << a5;
      3'd5: w = x[31:0] >> a5;
      3'd6: w = $signed(x[31:0]) >>> a5;
      default: return (x >> a) | (x << (7'd64 - {1'b0, a}));
    endcase
    return {{32{w[31]}}, w};
  endfunction

  logic [68:0] q[$];
  logic [68:0] e;
  int          k, n, last;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(3'd0, 1'b0, 64'h0, 64'h0, 6'd0, 5'd0);
    tick();
    in_valid = 1'b1;
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    tick();

    run_op("sll63",   3'd0, 1'b1, 64'h1,                64'h0,  6'd63, 5'h0a, 64'h8000000000000000);
    run_op("sra4",    3'd2, 1'b0, 64'h8000000000000000, 64'h4,  6'd0,  5'h0b, 64'hF800000000000000);
    run_op("srlw1",   3'd5, 1'b1, 64'hFFFFFFFF80000000, 64'h0,  6'd1,  5'h0c, 64'h0000000040000000);
    run_op("sraw1",   3'd6, 1'b1, 64'hFFFFFFFF80000000, 64'h0,  6'd1,  5'h0d, 64'hFFFFFFFFC0000000);
    run_op("ror8",    3'd7, 1'b1, 64'h0123456789ABCDEF, 64'h0,  6'd8,  5'h0e, 64'hEF0123456789ABCD);
    run_op("rol0",    3'd3, 1'b1, 64'h0123456789ABCDEF, 64'h0,  6'd0,  5'h0f, 64'h0123456789ABCDEF);
    run_op("sllw21",  3'd4, 1'b0, 64'h40000000,         64'h21, 6'd0,  5'h10, 64'hFFFFFFFF80000000);
    run_op("srl63",   3'd1, 1'b0, 64'h8000000000000000, 64'h3F, 6'd0,  5'h11, 64'h1);
    run_op("rol1",    3'd3, 1'b1, 64'h8000000000000001, 64'h0,  6'd1,  5'h12, 64'h3);
    run_op("ror63",   3'd7, 1'b1, 64'h1,                64'h0,  6'd63, 5'h13, 64'h2);
    run_op("sraw0",   3'd6, 1'b1, 64'h0000000080000000, 64'h0,  6'd0,  5'h14, 64'hFFFFFFFF80000000);
    run_op("srlw3f",  3'd5, 1'b0, 64'h0000000080000000, 64'h3F, 6'd0,  5'h15, 64'h1);
    run_op("sllw4",   3'd4, 1'b1, 64'hFFFFFFFF00000001, 64'h0,  6'd4,  5'h16, 64'h10);
    run_op("sra0",    3'd2, 1'b1, 64'h8000000000000000, 64'h0,  6'd0,  5'h17, 64'h8000000000000000);

    k = 0; n = 0; last = 0;
    for (int cyc = 0; cyc < 30 && n < 4; cyc++) begin
      in_valid = k < 4;
      drive(3'd0, 1'b1, 64'h1, 64'h0, 6'(k + 1), 5'(k + 20));
      out_ready = cyc >= 5;
      #1;
      if (cyc >= 2 && cyc < 5) begin
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_hold_data", out_data, 64'h2);
        chk("bp_hold_tag", 64'(out_tag), 64'd20);
      end
      if (cyc == 4) chk("bp_accepted", 64'(k), 64'd2);
      if (out_valid && out_ready) begin
        chk("bp_data", out_data, 64'h2 << n);
        chk("bp_tag", 64'(out_tag), 64'(20 + n));
        n++;
        last = cyc;
      end
      if (in_valid && in_ready) k++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_count", 64'(n), 64'd4);
    chk("bp_last_cycle", 64'(last), 64'd8);

    out_ready = 1'b0;
    drive(3'd0, 1'b1, 64'h1, 64'h0, 6'd1, 5'd1);
    in_valid = 1'b1;
    tick();
    drive(3'd0, 1'b1, 64'h1, 64'h0, 6'd2, 5'd2);
    tick();
    drive(3'd0, 1'b1, 64'h1, 64'h0, 6'd3, 5'd3);
    flush = 1'b1;
    #1;
    chk("fl_in_ready", 64'(in_ready), 64'd0);
    chk("fl_busy_before", 64'(busy), 64'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_busy_after", 64'(busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("fl_no_output", 64'(out_valid), 64'd0);
      tick();
    end
    run_op("fl_next", 3'd1, 1'b1, 64'hF0, 64'h0, 6'd4, 5'h1f, 64'hF);

    out_ready = 1'b0;
    drive(3'd0, 1'b1, 64'h1, 64'h0, 6'd4, 5'd7);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mr_vld", 64'(out_valid), 64'd1);
    chk("mr_data", out_data, 64'h10);
    rst = 1'b1;
    tick();
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_out_data", out_data, 64'd0);
    chk("mr_out_tag", 64'(out_tag), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    run_op("mr_next", 3'd2, 1'b0, 64'hFFFFFFFFFFFFFF00, 64'h8, 6'd0, 5'h05, 64'hFFFFFFFFFFFFFFFF);

    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      drive(3'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 6'($urandom), 5'($urandom));
      #1;
      if (in_valid && in_ready)
        q.push_back({in_tag, model(in_op, in_rs1, in_amt_src ? in_imm : in_rs2[5:0])});
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rand_spurious", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("rand_data", out_data, e[63:0]);
          chk("rand_tag", 64'(out_tag), 64'(e[68:64]));
        end
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (out_valid && q.size() != 0) begin
        e = q.pop_front();
        chk("drain_data", out_data, e[63:0]);
        chk("drain_tag", 64'(out_tag), 64'(e[68:64]));
      end
      tick();
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_shifter_pipe.md
Name: ex_shifter_pipe

Overview:
Parametrised, pipelined successor to the single-cycle EX shifter. It supports logical, arithmetic and rotate shifts on an XLEN-bit datapath, plus the RV64 word (*W) variants. The barrel levels are split across STAGES register stages, with valid/ready handshakes on both sides and a pipeline flush. It sits in the EX stage between the issue mux and the writeback arbiter.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64.
STAGES, 2, number of pipeline register stages; legal range 1..3; latency equals STAGES cycles.
SHAMT_W, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  discard all in-flight ops this cycle.
in_valid  in  1  request valid.
in_ready  out  1  shifter can accept a request this cycle.
in_op  in  3  000 sll, 001 srl, 010 sra, 011 rol, 100 sllw, 101 srlw, 110 sraw, 111 ror.
in_amt_src  in  1  1: use in_imm; 0: use in_rs2[SHAMT_W-1:0].
in_rs1  in  XLEN  source operand.
in_rs2  in  XLEN  register shift amount.
in_imm  in  SHAMT_W  immediate shift amount.
in_tag  in  5  destination tag; passed through unchanged.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_data  out  XLEN  result.
out_tag  out  5  tag of the result.
busy  out  1  OR of all stage valid bits.

Behaviour:
- Reset (rst=1 at an edge): every stage valid bit goes to 0 and every data/tag register goes to 0. Hence out_valid=0, out_data=0, out_tag=0, busy=0. in_ready=0 while rst is high.
- Amount: amt = in_amt_src ? in_imm : in_rs2[SHAMT_W-1:0].
- Word ops (100/101/110) mask amt to amt[4:0] and operate on rs1[31:0].
  - srlw zero-fills from bit 31.
  - sraw fills with rs1[31].
  - The 32-bit result is sign-extended to XLEN.
- When XLEN=32, word ops behave exactly like their non-word counterparts.
- rol and ror use the full amt; amt=0 returns rs1 unchanged.
- sra fills with rs1[XLEN-1]. amt=0 returns rs1 for every op; for word ops it returns sext(rs1[31:0]).
- Barrel split: SHAMT_W mux levels are distributed across the stages, with ceil(SHAMT_W/STAGES) levels per stage, LSB levels first. Op, fill bit and tag travel with the data. The final stage register drives out_* directly, with no combinational path from in_* to out_*.
- Latency: an op accepted in cycle N appears with out_valid=1 in cycle N+STAGES when there is no backpressure. Throughput is 1 op per cycle.
- Handshake:
  - A transfer happens when valid and ready are both high at a clock edge.
  - Stage k advances when it is empty or stage k+1 advances. The last stage advances on out_ready or when empty.
  - in_ready = ~rst & ~flush & (stage0 empty | stage0 advances).
  - Bubbles collapse: a stalled tail does not block empty upstream stages from filling.
  - While out_valid=1 and out_ready=0, out_data and out_tag hold stable.
  - in_* inputs are sampled only when accepted; they are don't-care otherwise.
- Flush:
  - Clears every valid bit at the edge. Data registers may keep stale values.
  - in_ready is 0 during the flush cycle, so no op is accepted that cycle.
  - out_valid may be 1 in the flush cycle; a transfer with out_ready=1 in that cycle is still a legal completion.
  - flush together with rst behaves as rst.
- Order: results leave in acceptance order. No op is dropped or duplicated except by flush or rst.
- Reset mid-operation: all in-flight ops are lost. The first accept after rst deasserts follows normal latency.
- Illegal parameters (XLEN not 32/64, STAGES outside 1..3) stop elaboration via a generate-time error.

Test Plan:
1. XLEN=64, STAGES=2: sll, rs1=0x1, imm=63, amt_src=1 -> cycle N+2: out_data=0x8000000000000000, out_tag equals the input tag.
2. sra, rs1=0x8000000000000000, rs2=4 -> out_data=0xF800000000000000. srlw, rs1=0xFFFFFFFF80000000, amt 1 -> out_data=0x0000000040000000. sraw, same rs1, amt 1 -> out_data=0xFFFFFFFFC0000000.
3. ror, rs1=0x0123456789ABCDEF, amt 8 -> out_data=0xEF0123456789ABCD. rol, same rs1, amt 0 -> out_data=0x0123456789ABCDEF. sllw, amt from rs2=0x21 (masked to 1), rs1=0x40000000 -> out_data=0xFFFFFFFF80000000.
4. Backpressure: 4 back-to-back ops, out_ready=0 for 5 cycles. Required response:
   - in_ready drops after STAGES ops are accepted.
   - out_data stays stable.
   - After out_ready=1, results arrive in order at 1 per cycle, none lost.
5. Flush with 2 ops in flight and in_valid=1 -> in_ready=0 in the flush cycle, busy=0 on the next cycle, no output for the flushed ops. The next op completes after STAGES cycles.
6. Sweep STAGES in {1,2,3} and XLEN=32: compare 10k random ops against a reference model, with random out_ready. Assert rst mid-stream -> out_valid=0 and out_data=0 in the next cycle.
